// File: rtl/slc3_test_top_if.sv
// Board-side pin bundle of the SLC-3 fetch test top: pushbuttons, switches, LEDs and 7-segment digits.
// The DUT takes the slave view; a board model or bench drives the master view.
interface slc3_test_top_if;
    logic       Run;
    logic       Continue;
    logic [9:0] SW;
    logic [9:0] LED;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] HEX2;
    logic [6:0] HEX3;
    logic [6:0] HEX4;
    logic [6:0] HEX5;

    modport master (
        output Run, Continue, SW,
        input  LED, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );

    modport slave (
        input  Run, Continue, SW,
        output LED, HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
    );
endinterface

// File: rtl/slc3_test_top.sv
// SLC-3 checkpoint-1 board top: fetch-only datapath stepping one instruction per Continue press,
// showing IR/PC on the 7-segment digits and HALT/PAUSE/MAR on the LEDs.
module slc3_test_top #(
    parameter int ADDR_W = 8
) (
    input logic          Clk,
    slc3_test_top_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [2:0] {
        S_HALT,
        S_F1,
        S_F2,
        S_F3,
        S_F4,
        S_PAUSE
    } state_e;

    // Holding both buttons together is the board's only reset source.
    logic rst_n;
    assign rst_n = bus.Run | bus.Continue;

    logic run_s1_q, run_s2_q, run_prev_q;
    logic cont_s1_q, cont_s2_q, cont_prev_q;
    logic run_press, cont_press;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            run_s1_q    <= 1'b1;
            run_s2_q    <= 1'b1;
            run_prev_q  <= 1'b1;
            cont_s1_q   <= 1'b1;
            cont_s2_q   <= 1'b1;
            cont_prev_q <= 1'b1;
        end else begin
            run_s1_q    <= bus.Run;
            run_s2_q    <= run_s1_q;
            run_prev_q  <= run_s2_q;
            cont_s1_q   <= bus.Continue;
            cont_s2_q   <= cont_s1_q;
            cont_prev_q <= cont_s2_q;
        end
    end

    assign run_press  = run_prev_q & ~run_s2_q;
    assign cont_press = cont_prev_q & ~cont_s2_q;

    logic [15:0] rom [DEPTH];
    logic [15:0] rom_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_rom
        assign rom[g] = {~8'(g), 8'(g)};
    end

    logic [15:0] mar_q;

    // NOTE: the memory read register carries no reset so it maps onto a block-RAM output port.
    always_ff @(posedge Clk) begin
        rom_q <= rom[mar_q[ADDR_W-1:0]];
    end

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] mar_d;
    logic [15:0] mdr_q, mdr_d;
    logic [15:0] ir_q, ir_d;

    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HALT;
            pc_q    <= '0;
            mar_q   <= '0;
            mdr_q   <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            ir_q    <= ir_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        ir_d    = ir_q;
        unique case (state_q)
            S_HALT: begin
                if (run_press) begin
                    pc_d    = {6'b0, bus.SW};
                    state_d = S_F1;
                end
            end
            S_F1: begin
                mar_d   = pc_q;
                pc_d    = pc_q + 16'd1;
                state_d = S_F2;
            end
            S_F2: state_d = S_F3;
            S_F3: begin
                mdr_d   = rom_q;
                state_d = S_F4;
            end
            S_F4: begin
                ir_d    = mdr_q;
                state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (cont_press) state_d = S_F1;
            end
            default: state_d = S_HALT;
        endcase
    end

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign bus.LED  = {state_q == S_HALT, state_q == S_PAUSE, mar_q[7:0]};
    assign bus.HEX0 = hex7(ir_q[3:0]);
    assign bus.HEX1 = hex7(ir_q[7:4]);
    assign bus.HEX2 = hex7(ir_q[11:8]);
    assign bus.HEX3 = hex7(ir_q[15:12]);
    assign bus.HEX4 = hex7(pc_q[3:0]);
    assign bus.HEX5 = hex7(pc_q[7:4]);

    // Upper MAR bits only matter as a full 16-bit address; the board shows the low byte.
    logic unused_mar_hi;
    assign unused_mar_hi = |mar_q[15:8];
endmodule

// File: tb/tb_slc3_test_top.sv
// Self-checking bench for slc3_test_top: a reference fetch model pushes expected IR/PC/LED/HEX
// snapshots into a scoreboard, popped when the DUT reaches PAUSE.
module tb_slc3_test_top;
    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    slc3_test_top_if bus ();
    slc3_test_top #(.ADDR_W(8)) dut (.Clk(Clk), .bus(bus));

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] pc;
        logic [9:0]  led;
        logic [6:0]  h5, h4, h3, h2, h1, h0;
    } obs_t;

    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    obs_t        sb[$];
    obs_t        exp_o, got_o, last_o, reset_o;
    int          n_err = 0;
    int          n_chk = 0;
    int          cycles;
    logic [15:0] model_pc;

    function automatic obs_t make_obs(input logic [15:0] ir, input logic [15:0] pc, input logic [9:0] led);
        obs_t o;
        o.ir  = ir;
        o.pc  = pc;
        o.led = led;
        o.h0  = SEG[ir[3:0]];
        o.h1  = SEG[ir[7:4]];
        o.h2  = SEG[ir[11:8]];
        o.h3  = SEG[ir[15:12]];
        o.h4  = SEG[pc[3:0]];
        o.h5  = SEG[pc[7:4]];
        return o;
    endfunction

    function automatic obs_t model_fetch(input logic [15:0] pc_fetch);
        logic [7:0] idx;
        idx = pc_fetch[7:0];
        return make_obs({~idx, idx}, pc_fetch + 16'd1, {2'b01, idx});
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.ir  = dut.ir_q;
        o.pc  = dut.pc_q;
        o.led = bus.LED;
        o.h0  = bus.HEX0;
        o.h1  = bus.HEX1;
        o.h2  = bus.HEX2;
        o.h3  = bus.HEX3;
        o.h4  = bus.HEX4;
        o.h5  = bus.HEX5;
        return o;
    endfunction

    // Waits for the next entry into PAUSE, releasing the buttons after release_after cycles.
    task automatic wait_pause(input int release_after, output int n);
        logic seen_low;
        seen_low = !bus.LED[8];
        n = 0;
        while (!(seen_low && bus.LED[8]) && n < 200) begin
            @(negedge Clk);
            n++;
            if (n == release_after) begin
                bus.Run      = 1'b1;
                bus.Continue = 1'b1;
            end
            if (!bus.LED[8]) seen_low = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.Run = 1'b1; bus.Continue = 1'b1; bus.SW = '0;
        repeat (3) @(negedge Clk);
        bus.Run = 1'b0; bus.Continue = 1'b0;
        #1;
        got_o = sample(); n_chk++;
        if (got_o !== reset_o) begin n_err++; $display("FAIL reset_assert: got %h want %h", got_o, reset_o); end
        repeat (2) @(negedge Clk);
        bus.Run = 1'b1; bus.Continue = 1'b1;
        repeat (5) @(negedge Clk);
        got_o = sample(); n_chk++;
        if (got_o !== reset_o) begin n_err++; $display("FAIL reset_release: got %h want %h", got_o, reset_o); end
    endtask

    task automatic test_first_fetch();
        bus.SW = 10'h003;
        model_pc = 16'h0003;
        sb.push_back(model_fetch(model_pc));
        model_pc++;
        @(negedge Clk);
        bus.Run = 1'b0;
        wait_pause(4, cycles);
        n_chk++;
        if (cycles !== 7) begin n_err++; $display("FAIL run_latency: got %0d want 7", cycles); end
        exp_o = sb.pop_front(); got_o = sample(); n_chk++;
        if (got_o !== exp_o) begin n_err++; $display("FAIL first_fetch: got %h want %h", got_o, exp_o); end
    endtask

    task automatic test_continue();
        sb.push_back(model_fetch(model_pc));
        model_pc++;
        @(negedge Clk);
        bus.Continue = 1'b0;
        wait_pause(1000, cycles);
        n_chk++;
        if (cycles !== 7) begin n_err++; $display("FAIL continue_latency: got %0d want 7", cycles); end
        exp_o = sb.pop_front(); got_o = sample(); n_chk++;
        if (got_o !== exp_o) begin n_err++; $display("FAIL continue_fetch: got %h want %h", got_o, exp_o); end
        last_o = exp_o;
        repeat (93) @(negedge Clk);
        bus.Continue = 1'b1;
        repeat (10) @(negedge Clk);
        got_o = sample(); n_chk++;
        if (got_o !== last_o) begin n_err++; $display("FAIL continue_held_once: got %h want %h", got_o, last_o); end
    endtask

    task automatic test_ignored_presses();
        bus.SW = 10'h2A5;
        @(negedge Clk);
        bus.Run = 1'b0;
        repeat (4) @(negedge Clk);
        bus.Run = 1'b1;
        repeat (10) @(negedge Clk);
        got_o = sample(); n_chk++;
        if (got_o !== last_o) begin n_err++; $display("FAIL run_in_pause: got %h want %h", got_o, last_o); end
        repeat (100) @(negedge Clk);
        got_o = sample(); n_chk++;
        if (got_o !== last_o) begin n_err++; $display("FAIL idle_stable: got %h want %h", got_o, last_o); end
    endtask

    // A second Continue press lands while the fetch is in F4 and must be dropped.
    task automatic test_drop_during_fetch();
        sb.push_back(model_fetch(model_pc));
        model_pc++;
        for (int c = 0; c < 30; c++) begin
            @(negedge Clk);
            if (c == 0 || c == 4) bus.Continue = 1'b0;
            if (c == 2 || c == 8) bus.Continue = 1'b1;
        end
        exp_o = sb.pop_front(); got_o = sample(); n_chk++;
        if (got_o !== exp_o) begin n_err++; $display("FAIL press_dropped: got %h want %h", got_o, exp_o); end
    endtask

    task automatic test_wrap();
        @(negedge Clk);
        bus.Run = 1'b0; bus.Continue = 1'b0;
        #1;
        got_o = sample(); n_chk++;
        if (got_o !== reset_o) begin n_err++; $display("FAIL wrap_reset: got %h want %h", got_o, reset_o); end
        @(negedge Clk);
        bus.Run = 1'b1; bus.Continue = 1'b1;
        bus.SW = 10'h3FF;
        model_pc = 16'h03FF;
        sb.push_back(model_fetch(model_pc));
        model_pc++;
        repeat (3) @(negedge Clk);
        bus.Run = 1'b0;
        wait_pause(4, cycles);
        exp_o = sb.pop_front(); got_o = sample(); n_chk++;
        if (got_o !== exp_o) begin n_err++; $display("FAIL wrap_run: got %h want %h", got_o, exp_o); end
        for (int i = 0; i < 2; i++) begin
            sb.push_back(model_fetch(model_pc));
            model_pc++;
            @(negedge Clk);
            bus.Continue = 1'b0;
            wait_pause(4, cycles);
            exp_o = sb.pop_front(); got_o = sample(); n_chk++;
            if (got_o !== exp_o) begin n_err++; $display("FAIL wrap_cont%0d: got %h want %h", i, got_o, exp_o); end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            sb.push_back(model_fetch(model_pc));
            model_pc++;
            @(negedge Clk);
            bus.Continue = 1'b0;
            wait_pause(2, cycles);
            exp_o = sb.pop_front(); got_o = sample(); n_chk++;
            if (got_o !== exp_o) begin n_err++; $display("FAIL back_to_back%0d: got %h want %h", i, got_o, exp_o); end
        end
    endtask

    // Both buttons go low while the fetch sits in F2; reset must take effect with no clock edge.
    task automatic test_async_abort();
        @(negedge Clk);
        bus.Continue = 1'b0;
        repeat (4) @(negedge Clk);
        bus.Run = 1'b0;
        #1;
        got_o = sample(); n_chk++;
        if (got_o !== reset_o) begin n_err++; $display("FAIL abort_async: got %h want %h", got_o, reset_o); end
        @(negedge Clk);
        bus.Run = 1'b1; bus.Continue = 1'b1;
        repeat (3) @(negedge Clk);
        got_o = sample(); n_chk++;
        if (got_o !== reset_o) begin n_err++; $display("FAIL abort_release: got %h want %h", got_o, reset_o); end
    endtask

    initial begin
        reset_o = make_obs(16'h0000, 16'h0000, 10'h200);
        test_reset();
        test_first_fetch();
        test_continue();
        test_ignored_presses();
        test_drop_during_fetch();
        test_wrap();
        test_back_to_back();
        test_async_abort();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
